// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined carry-lookahead adder/subtractor for the ALU datapath.
// WIDTH is cut into STAGES slices. Each slice adds its bit range using 4-bit CLA
// groups, and the slice carry-out is registered into the next stage. A single
// output register holds sum/cout/ovf/zero behind a valid/ready handshake.

// ---------------------------------------------------------------------------
// 4-bit carry-lookahead group: bit carries plus group propagate/generate.
// ---------------------------------------------------------------------------
module cla_group4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_s,
   output logic       o_p,
   output logic       o_g,
   output logic       o_c3
);
   logic [3:0] w_p;
   logic [3:0] w_g;
   logic [3:0] w_c;

   // Bit-level propagate/generate, then fully expanded lookahead carries.
   always_comb begin
      w_p    = i_a ^ i_b;
      w_g    = i_a & i_b;
      w_c[0] = i_cin;
      w_c[1] = w_g[0] | (w_p[0] & i_cin);
      w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
      w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & i_cin);
      o_s    = w_p ^ w_c;
      o_p    = &w_p;
      o_g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
      o_c3   = w_c[3];
   end
endmodule

// ---------------------------------------------------------------------------
// One pipeline slice: SW/4 CLA groups whose carry-ins come from group P/G.
// ---------------------------------------------------------------------------
module cla_slice #(
   parameter int SW = 16
) (
   input  logic [SW-1:0] i_a,
   input  logic [SW-1:0] i_b,
   input  logic          i_cin,
   output logic [SW-1:0] o_sum,
   output logic          o_cout,
   output logic          o_cmsb
);
   localparam int NG = SW / 4;

   logic [NG-1:0] w_gp;
   logic [NG-1:0] w_gg;
   logic [NG-1:0] w_gc3;
   logic [NG:0]   w_gcin;

   // Group carry-ins depend only on group P/G and the slice carry-in; the
   // bit-level chain never crosses a group boundary.
   always_comb begin
      w_gcin[0] = i_cin;
      for (int j = 0; j < NG; j++) begin
         w_gcin[j+1] = w_gg[j] | (w_gp[j] & w_gcin[j]);
      end
   end

   for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group4 u_grp (
         .i_a   (i_a[j*4 +: 4]),
         .i_b   (i_b[j*4 +: 4]),
         .i_cin (w_gcin[j]),
         .o_s   (o_sum[j*4 +: 4]),
         .o_p   (w_gp[j]),
         .o_g   (w_gg[j]),
         .o_c3  (w_gc3[j])
      );
   end

   assign o_cout = w_gcin[NG];
   // Carry into the slice MSB; only the top slice uses it, for signed overflow.
   assign o_cmsb = w_gc3[NG-1];
endmodule

// ---------------------------------------------------------------------------
// Top: operand conditioning, slice pipeline, output register and handshake.
// ---------------------------------------------------------------------------
module cla_adder_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_sub,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf,
   output logic             o_zero
);
   localparam int SW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   if (STAGES < 1 || STAGES > 4 || (WIDTH % (4 * STAGES)) != 0) begin : g_bad_cfg
      $error("cla_adder_pipe: WIDTH must be a multiple of 4*STAGES, STAGES in 1..4");
   end

   // Per-stage view: the values entering slice k (stage 0 = the input ports).
   logic [STAGES-1:0][WIDTH-1:0] w_st_a;
   logic [STAGES-1:0][WIDTH-1:0] w_st_bp;
   logic [STAGES-1:0][WIDTH-1:0] w_st_sum;
   logic [STAGES-1:0][WIDTH-1:0] w_nx_sum;
   logic [STAGES-1:0][SW-1:0]    w_sl_sum;
   logic [STAGES-1:0]            w_st_c;
   logic [STAGES-1:0]            w_st_vld;
   logic [STAGES-1:0]            w_sl_cout;
   logic [STAGES-1:0]            w_sl_cmsb;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;
   logic [WIDTH-1:0] w_fin_sum;
   logic             w_adv;

   // The whole pipe moves together whenever the output slot is free or drains.
   assign w_adv      = i_out_ready || !r_out_valid;
   assign o_in_ready = w_adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      if (k == 0) begin : g_in
         // Subtraction is a + ~b + 1; cin is ignored for sub.
         assign w_st_a[0]   = i_a;
         assign w_st_bp[0]  = i_sub ? ~i_b : i_b;
         assign w_st_c[0]   = i_sub ? 1'b1 : i_cin;
         assign w_st_sum[0] = '0;
         assign w_st_vld[0] = i_in_valid;
      end else begin : g_reg
         logic [WIDTH-1:0] r_a;
         logic [WIDTH-1:0] r_bp;
         logic [WIDTH-1:0] r_psum;
         logic             r_c;
         logic             r_vld;

         // Stage register: carry, pending operands and completed low sum bits.
         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               r_a    <= '0;
               r_bp   <= '0;
               r_psum <= '0;
               r_c    <= 1'b0;
               r_vld  <= 1'b0;
            end else if (w_adv) begin
               r_a    <= w_st_a[k-1];
               r_bp   <= w_st_bp[k-1];
               r_psum <= w_nx_sum[k-1];
               r_c    <= w_sl_cout[k-1];
               r_vld  <= w_st_vld[k-1];
            end
         end

         assign w_st_a[k]   = r_a;
         assign w_st_bp[k]  = r_bp;
         assign w_st_sum[k] = r_psum;
         assign w_st_c[k]   = r_c;
         assign w_st_vld[k] = r_vld;
      end

      cla_slice #(.SW(SW)) u_slice (
         .i_a    (w_st_a[k][k*SW +: SW]),
         .i_b    (w_st_bp[k][k*SW +: SW]),
         .i_cin  (w_st_c[k]),
         .o_sum  (w_sl_sum[k]),
         .o_cout (w_sl_cout[k]),
         .o_cmsb (w_sl_cmsb[k])
      );

      // Sum bits at and above slice k are still zero here, so OR-ing in the
      // slice result assembles the partial sum without a mask.
      assign w_nx_sum[k] = w_st_sum[k] | (WIDTH'(w_sl_sum[k]) << (k * SW));
   end

   assign w_fin_sum = w_nx_sum[LAST];

   // Output register; result fields only load on a valid op so they hold
   // their last value across bubbles and stalls.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= w_st_vld[LAST];
         if (w_st_vld[LAST]) begin
            r_sum  <= w_fin_sum;
            r_cout <= w_sl_cout[LAST];
            r_ovf  <= w_sl_cmsb[LAST] ^ w_sl_cout[LAST];
            r_zero <= (w_fin_sum == '0);
         end
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_sum       = r_sum;
   assign o_cout      = r_cout;
   assign o_ovf       = r_ovf;
   assign o_zero      = r_zero;
endmodule
